// File: rtl/cla_pipe_adder.sv
// Pipelined Kogge-Stone carry-lookahead adder/subtractor with valid/ready flow control.
// Saturation on signed overflow is built only when CLA_PIPE_SAT_EN is defined.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned LEVELS = $clog2(WIDTH);
`ifdef CLA_PIPE_SAT_EN
  // Side-band per beat: bitwise propagate, carry-in, sat request, sign of a.
  localparam int unsigned XW = WIDTH + 3;
`else
  localparam int unsigned XW = WIDTH + 1;
  logic unused_sat;
  assign unused_sat = sat;
`endif

  // True when an internal pipeline register sits after prefix level lvl.
  function automatic bit is_boundary(int unsigned lvl);
    bit hit;
    hit = 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if ((k * LEVELS + STAGES - 1) / STAGES == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Level 0 forms bitwise (G,P); levels 1..LEVELS are Kogge-Stone combine rows.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    logic [WIDTH-1:0] g_c, p_c, g_s, p_s;
    logic [XW-1:0]    x_c, x_s;
    logic             v_c, v_s;

    if (l == 0) begin : g_leaf
      logic [WIDTH-1:0] bx;
      assign bx  = sub ? ~b : b;
      assign g_c = a & bx;
      assign p_c = a ^ bx;
      assign v_c = in_valid;
`ifdef CLA_PIPE_SAT_EN
      assign x_c = {p_c, sub | cin, sat, a[WIDTH-1]};
`else
      assign x_c = {p_c, sub | cin};
`endif
    end else begin : g_node
      localparam int unsigned D = 1 << (l - 1);
      // Bits below D already span down to bit 0 and pass through unchanged.
      assign g_c = lvl[l-1].g_s | (lvl[l-1].p_s & (lvl[l-1].g_s << D));
      assign p_c = lvl[l-1].p_s & ((lvl[l-1].p_s << D) | ~({WIDTH{1'b1}} << D));
      assign x_c = lvl[l-1].x_s;
      assign v_c = lvl[l-1].v_s;
    end

    if (is_boundary(l)) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_s <= 1'b0;
          g_s <= '0;
          p_s <= '0;
          x_s <= '0;
        end else if (en) begin
          v_s <= v_c;
          g_s <= g_c;
          p_s <= p_c;
          x_s <= x_c;
        end
      end
    end else begin : g_pass
      assign v_s = v_c;
      assign g_s = g_c;
      assign p_s = p_c;
      assign x_s = x_c;
    end
  end

  logic [WIDTH-1:0] g_top, p_top, p0, sum_raw, sum_c;
  logic [WIDTH:0]   carry;
  logic             c0, ovf_c;

  assign g_top   = lvl[LEVELS].g_s;
  assign p_top   = lvl[LEVELS].p_s;
  assign p0      = lvl[LEVELS].x_s[XW-1 -: WIDTH];
  assign c0      = lvl[LEVELS].x_s[XW-WIDTH-1];
  assign carry   = {g_top | (p_top & {WIDTH{c0}}), c0};
  assign sum_raw = p0 ^ carry[WIDTH-1:0];
  assign ovf_c   = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef CLA_PIPE_SAT_EN
  logic sat_q, a_neg;
  assign sat_q = lvl[LEVELS].x_s[1];
  assign a_neg = lvl[LEVELS].x_s[0];

  // On overflow the true sign equals a's sign for both add and subtract.
  always_comb begin
    sum_c = sum_raw;
    if (sat_q && ovf_c) begin
      sum_c = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_c = sum_raw;
`endif

  // Output register: final pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= lvl[LEVELS].v_s;
      sum       <= sum_c;
      cout      <= carry[WIDTH];
      ovf       <= ovf_c;
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes, the next generation of the team's fixed-width combinational CLA. It computes the carries with a Kogge-Stone parallel-prefix tree and splits the tree across a configurable number of register stages. It reports signed overflow and optionally saturates the result. It sits between ALU operand muxes and the writeback/accumulator path, where the 16-bit single-cycle adder no longer meets timing at wider widths.

## Interface
- WIDTH, 32: operand width; power of two, 4..64.
- STAGES, 2: pipeline register stages, 1..log2(WIDTH).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: a - b (a + ~b + 1); 0: a + b + cin.
- sat  in  1  saturate on signed overflow; effective only with CLA_PIPE_SAT_EN.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  out  1  signed two's-complement overflow of the unsaturated result.

## Operation
- Beat accepted when in_valid && in_ready. Result delivered when out_valid && out_ready.
- Generate/propagate per bit: G=a&b', P=a^b', with b'=sub?~b:b. Carry-in c0=sub?1:cin.
- Prefix tree has L=log2(WIDTH) levels of (G,P) combine: G=Gh|(Ph&Gl), P=Ph&Pl.
- Pipeline register k (k=1..STAGES) sits after level ceil(k*L/STAGES). The last register is the output register, and the sum XOR is computed before it.
- Carry into bit i = G[i-1:0] | (P[i-1:0]&c0). sum[i]=P[i]^carry_i. cout=carry into bit WIDTH.
- ovf = carry into MSB XOR cout.
- Each stage holds a valid bit plus its data. Order is strictly preserved, with no reordering or dropping.
- Global stall: en = !out_valid | out_ready. All stage registers and valid bits load only when en. in_ready = en, combinational from out_valid/out_ready and never from in_valid.
- A bubble entering (in_valid=0 while en) clears that stage's valid bit.

## Timing
- Latency: a beat accepted at cycle t produces out_valid at t+STAGES, provided no stall.
- Throughput: one beat per cycle while out_ready=1.
- While out_valid=1 and out_ready=0: sum/cout/ovf/out_valid hold stable, in_ready=0, and no internal stage advances.
- Reset (rst_n low, asynchronous): all stage valid bits=0, out_valid=0, sum=0, cout=0, ovf=0. in_ready is therefore 1 during and after reset.
- Reset mid-operation: all in-flight beats are discarded, and no result from them ever appears.
- On the first clock after rst_n deasserts, the block is ready to accept.
- Simultaneous out-handshake and in-handshake in the same cycle: both complete, and the pipeline advances by one.
- STAGES=1: the tree is fully combinational into a single output register, giving 1-cycle latency.

## Configuration
- CLA_PIPE_SAT_EN defined: when sat=1 and ovf=1, sum = 0x7F..F if the true result is positive (operand sign 0 for add; a≥0, b<0 for sub), else 0x80..0.
- CLA_PIPE_SAT_EN defined: ovf and cout still report the unsaturated values.
- CLA_PIPE_SAT_EN defined: sat is registered alongside the data through every stage.
- CLA_PIPE_SAT_EN undefined: the sat port exists but is ignored, no saturation logic is built, and sum is always the wrapped result.

## Test plan
- WIDTH=16, STAGES=2; a=0xFFFF, b=0x0001, cin=0, sub=0 at cycle 0 -> out_valid at cycle 2, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0, sat=1 -> macro off: sum=0x8000, ovf=1, cout=0; macro on: sum=0x7FFF, ovf=1.
- sub=1, a=0x8000, b=0x0001, sat=1 -> macro off: sum=0x7FFF, cout=1, ovf=1; macro on: sum=0x8000, ovf=1.
- Back-to-back beats a=1,2,3,4 (b=0x0010); hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 during the hold, outputs held stable, results 0x11,0x12,0x13,0x14 emitted in order with none lost or duplicated.
- Two beats in flight; pulse rst_n low mid-cycle -> out_valid=0 and sum=0 immediately, in_ready=1, and no stale beat appears after release.
- Random add/sub/cin/sat with random out_ready (50%) for WIDTH∈{8,32,64} and every legal STAGES -> scoreboard matches a golden a±b model bit-exactly for sum/cout/ovf, and latency equals STAGES when unstalled.
